// File: rtl/c3lib_ckmux4_sel_ctrl_if.sv
// c3lib_ckmux4_sel_ctrl_if: request handshake and mux/gate controls of the clock-select sequencer
interface c3lib_ckmux4_sel_ctrl_if;
  logic       req;
  logic [1:0] req_sel;
  logic       ack;
  logic       req_drop;
  logic       busy;
  logic       s0;
  logic       s1;
  logic       ck_gate_en;
  logic [1:0] cur_sel;
  modport master (output req, req_sel, input ack, req_drop, busy, s0, s1, ck_gate_en, cur_sel);
  modport slave  (input req, req_sel, output ack, req_drop, busy, s0, s1, ck_gate_en, cur_sel);
endinterface

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// c3lib_ckmux4_sel_ctrl: gates the muxed clock, switches the 4:1 select, waits to settle, then re-enables
module c3lib_ckmux4_sel_ctrl #(
  parameter logic [1:0] RESET_SEL  = 2'b00,
  parameter int         GATE_DLY   = 4,
  parameter int         SETTLE_DLY = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  c3lib_ckmux4_sel_ctrl_if.slave  bus
);
  localparam logic [7:0] GATE_LD   = 8'(GATE_DLY - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_DLY - 1);
  typedef enum logic [1:0] {INIT, IDLE, GATE_WAIT, SETTLE} state_t;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_sel;
  logic [1:0] r_tgt;
  logic       r_gate;
  logic       r_ack;
  logic       r_drop;
  logic       r_busy;
  logic       w_done;
  assign w_done = r_cnt == 8'd0;
  // counter free-runs down to zero and holds; every state entry reloads it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= SETTLE_LD;
      r_sel   <= RESET_SEL;
      r_tgt   <= RESET_SEL;
      r_gate  <= 1'b0;
      r_ack   <= 1'b0;
      r_drop  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_ack  <= 1'b0;
      r_drop <= bus.req && r_state != IDLE;
      r_cnt  <= w_done ? r_cnt : r_cnt - 8'd1;
      case (r_state)
        INIT:
          if (w_done) begin
            r_gate  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        IDLE:
          if (bus.req && bus.req_sel == r_sel) r_ack <= 1'b1;
          else if (bus.req) begin
            r_tgt   <= bus.req_sel;
            r_gate  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= GATE_LD;
            r_state <= GATE_WAIT;
          end
        GATE_WAIT:
          if (w_done) begin
            r_sel   <= r_tgt;
            r_cnt   <= SETTLE_LD;
            r_state <= SETTLE;
          end
        SETTLE:
          if (w_done) begin
            r_gate  <= 1'b1;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= INIT;
      endcase
    end
  assign bus.ack        = r_ack;
  assign bus.req_drop   = r_drop;
  assign bus.busy       = r_busy;
  assign bus.s0         = r_sel[0];
  assign bus.s1         = r_sel[1];
  assign bus.ck_gate_en = r_gate;
  assign bus.cur_sel    = r_sel;
  // the select may only move while the downstream clock is gated off
  a_sel_gated: assert property (@(posedge clk) disable iff (!rst_n) $changed(r_sel) |-> !r_gate);
endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
// tb_c3lib_ckmux4_sel_ctrl: scoreboard bench; requests push expected ack/drop events, a monitor pops them
module tb_c3lib_ckmux4_sel_ctrl;
  localparam logic [1:0] RS = 2'b10;
  localparam int GD = 4;
  localparam int SD = 8;
  typedef struct {bit is_ack; int cyc; logic [1:0] sel;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc, total, bad, gcnt;
  bit skip = 1'b1;
  logic [1:0] psel;
  logic [1:0] m_cur;
  int m_free;
  exp_t q[$];
  c3lib_ckmux4_sel_ctrl_if bus();
  c3lib_ckmux4_sel_ctrl #(.RESET_SEL(RS), .GATE_DLY(GD), .SETTLE_DLY(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic push(exp_t e);
    int i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask
  // caller sits on a negedge; the request is sampled at the next posedge
  task automatic do_req(logic [1:0] sel);
    int t0 = cyc + 1;
    bus.req = 1'b1;
    bus.req_sel = sel;
    if (t0 < m_free) push('{1'b0, t0, 2'b00});
    else if (sel == m_cur) begin
      push('{1'b1, t0, sel});
      m_free = t0 + 1;
    end else begin
      push('{1'b1, t0 + GD + SD, sel});
      m_cur = sel;
      m_free = t0 + GD + SD + 1;
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask
  task automatic chk_reset_vals(string n);
    chk({n, "_s10"}, {bus.s1, bus.s0}, RS);
    chk({n, "_cur"}, bus.cur_sel, RS);
    chk({n, "_gate"}, bus.ck_gate_en, 0);
    chk({n, "_busy"}, bus.busy, 1);
    chk({n, "_ack"}, bus.ack, 0);
    chk({n, "_drop"}, bus.req_drop, 0);
  endtask
  task automatic pulse_rst(string n);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals(n);
    #1 rst_n = 1'b1;
    q.delete();
    m_cur = RS;
    m_free = SD + 1;
  endtask
  task automatic wait_gate_rise(string n);
    for (int i = 0; i < 40 && !bus.ck_gate_en; i++) @(negedge clk);
    chk({n, "_rise_cyc"}, cyc, SD);
    chk({n, "_rise_sel"}, {bus.s1, bus.s0}, RS);
  endtask
  task automatic pop_chk(bit k);
    exp_t e;
    if (q.size() == 0 || q[0].cyc != cyc || q[0].is_ack != k) begin
      total++;
      bad++;
      $display("FAIL sb_%s: unexpected event at cyc %0d, next expected is %s at cyc %0d", k ? "ack" : "drop", cyc,
               q.size() == 0 ? "none" : (q[0].is_ack ? "ack" : "drop"), q.size() == 0 ? -1 : q[0].cyc);
    end else begin
      e = q.pop_front();
      total++;
      if (k) begin
        chk("ack_cur_sel", bus.cur_sel, e.sel);
        chk("ack_s10", {bus.s1, bus.s0}, e.sel);
        chk("ack_gate", bus.ck_gate_en, 1);
        chk("ack_busy", bus.busy, 0);
      end
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL sb_missing: %s expected at cyc %0d not seen by cyc %0d", q[0].is_ack ? "ack" : "drop", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (bus.ack) pop_chk(1'b1);
    if (bus.req_drop) pop_chk(1'b0);
  end
  // every select change must follow at least GD sampled cycles of gate off
  always @(negedge clk or negedge rst_n)
    if (!rst_n) skip = 1'b1;
    else if (skip) begin
      skip = 1'b0;
      psel = {bus.s1, bus.s0};
      gcnt = bus.ck_gate_en ? 0 : 1;
    end else begin
      if ({bus.s1, bus.s0} != psel) begin
        total++;
        if (bus.ck_gate_en || gcnt < GD) begin
          bad++;
          $display("FAIL sel_invariant: sel %0d->%0d with gate=%0d after %0d gated cycles, need gate=0 and >=%0d",
                   psel, {bus.s1, bus.s0}, bus.ck_gate_en, gcnt, GD);
        end
      end
      psel = {bus.s1, bus.s0};
      gcnt = bus.ck_gate_en ? 0 : gcnt + 1;
    end
  initial begin
    bus.req = 1'b0;
    bus.req_sel = 2'b00;
    m_cur = RS;
    m_free = SD + 1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    wait_gate_rise("init");
    do_req(2'b00);
    repeat (GD + SD + 1) @(negedge clk);
    do_req(2'b01);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("seq_busy_k%0d", k), bus.busy, k < GD + SD);
      chk($sformatf("seq_gate_k%0d", k), bus.ck_gate_en, k >= GD + SD);
      chk($sformatf("seq_sel_k%0d", k), {bus.s1, bus.s0}, k >= GD ? 1 : 0);
      @(negedge clk);
    end
    do_req(2'b01);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("same_gate_k%0d", k), bus.ck_gate_en, 1);
      chk($sformatf("same_busy_k%0d", k), bus.busy, 0);
      @(negedge clk);
    end
    do_req(2'b11);
    @(negedge clk);
    do_req(2'b00);
    repeat (8) @(negedge clk);
    do_req(2'b10);
    do_req(2'b01);
    repeat (3) @(negedge clk);
    chk("final_sel", bus.cur_sel, 2'b11);
    do_req(2'b00);
    repeat (6) @(negedge clk);
    pulse_rst("settle_rst");
    @(negedge clk);
    do_req(2'b01);
    wait_gate_rise("reinit");
    for (int n = 0; n < 3000; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_req(2'($urandom_range(0, 3)));
    end
    repeat (GD + SD + 5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c3lib_ckmux4_sel_ctrl.md
# c3lib_ckmux4_sel_ctrl

Single-clock sequencer that drives the select inputs of a 4:1 hardened clock mux tree and the enable of the downstream clock gate, so that a functional clock-source change happens only while the muxed clock is gated off. A requester asks for a new source with a `req`/`ack` handshake. The block gates the clock, waits for the old clock to drain, switches `s1`/`s0`, waits for the new clock to settle, and then re-enables the gate. It sits beside the 4:1 clock mux in the clock-distribution logic and is clocked by an always-running reference clock that is not one of the muxed clocks.

## Interface
Parameters:
- `RESET_SEL`, default 2'b00: source selected while in reset and after reset.
- `GATE_DLY`, default 4: cycles the gate is held off before the select changes. Legal range 1..255.
- `SETTLE_DLY`, default 8: cycles after the select change before the gate re-enables. Also used as the post-reset wait. Legal range 1..255.

Ports:
- `clk` in 1: reference clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in 1: single-cycle request strobe.
- `req_sel` in 2: requested source {s1,s0}, sampled with `req`.
- `ack` out 1: single-cycle pulse when a request completes.
- `req_drop` out 1: single-cycle pulse when a `req` is ignored because the block is busy.
- `busy` out 1: sequence in progress (state ≠ IDLE).
- `s0` out 1: mux select LSB, registered.
- `s1` out 1: mux select MSB, registered.
- `ck_gate_en` out 1: downstream clock-gate enable, registered, 1 = clock passes.
- `cur_sel` out 2: currently applied {s1,s0}.

## Operation
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values:
  - {s1,s0} = `cur_sel` = `RESET_SEL`
  - `ck_gate_en` = 0
  - `ack` = 0, `req_drop` = 0
  - `busy` = 1
  - state INIT, counter = `SETTLE_DLY`-1
- States:
  - **INIT**: counter decrements each cycle. At the edge where the counter is 0, the block sets `ck_gate_en`=1, sets `busy`=0 and moves to IDLE. No `ack` is issued.
  - **IDLE** with `req`=1 and `req_sel`=`cur_sel`: pulse `ack` next cycle. Stay in IDLE. The gate is untouched and `busy` stays 0.
  - **IDLE** with `req`=1 and `req_sel`≠`cur_sel`:
    - latch `req_sel` as target
    - set `ck_gate_en`=0 and `busy`=1
    - load counter = `GATE_DLY`-1
    - move to GATE_WAIT
  - **GATE_WAIT**: counter decrements. At the edge where the counter is 0:
    - {s1,s0} and `cur_sel` take the target value
    - load counter = `SETTLE_DLY`-1
    - move to SETTLE
  - **SETTLE**: counter decrements. At the edge where the counter is 0:
    - set `ck_gate_en`=1, `ack`=1 (for one cycle) and `busy`=0
    - move to IDLE
- `req` in any state other than IDLE is ignored: `req_drop` pulses for one cycle and the latched target is unchanged. This includes a `req` during INIT, and a `req` on the same edge on which SETTLE exits, because the state is still SETTLE at that edge.
- Invariant: {s1,s0} changes only while `ck_gate_en`=0, and only after `ck_gate_en` has been 0 for at least `GATE_DLY` cycles.
- The counter is 8 bits and never wraps: it is reloaded on every state entry and only decremented from a nonzero value.
- Reset asserted mid-sequence: the block immediately (asynchronously) returns to the reset values. The select is forced to `RESET_SEL` with the gate off. No `ack` is issued for the aborted request.

## Timing
- Request sampled at edge T0 (IDLE, different select):
  - `busy`=1 and `ck_gate_en`=0 from T0.
  - {s1,s0} updates at T0+`GATE_DLY`.
  - `ck_gate_en`=1, `ack`=1 and `busy`=0 at T0+`GATE_DLY`+`SETTLE_DLY`.
  - `ack` falls at the next edge.
- Request for the same select: `ack` at T0, width 1 cycle. The next `req` is accepted at T0+1.
- After reset release, the first rising edge counts as cycle 1. `ck_gate_en` rises on edge `SETTLE_DLY`.
- Back-to-back requests: the earliest accepted `req` is on the edge after `ack` rises.

## Test plan
- Reset with `RESET_SEL`=2'b10 and `SETTLE_DLY`=8: after reset, {s1,s0}=10 and `ck_gate_en`=0, and `ck_gate_en` rises exactly at edge 8. Pulse `rst_n` low for a partial cycle: outputs return to reset values immediately.
- `GATE_DLY`=4, `SETTLE_DLY`=8, `req` with `req_sel`=2'b01 at T0 from 00:
  - gate low at T0
  - {s1,s0}=01 at T0+4
  - gate high and `ack` at T0+12
  - `busy` high exactly from T0 to T0+12
- `req_sel` equal to `cur_sel`: `ack` at T0 and `ck_gate_en` stays 1 throughout.
- `req` at T0+2 and again at T0+11 during a sequence: `req_drop` pulses at each, and the final select equals the first request.
- Assert `rst_n` during SETTLE: select reverts to `RESET_SEL`, gate goes 0, no `ack`, and INIT restarts.
- Random requests over 10k cycles: a checker confirms every {s1,s0} change happens while the gate is 0 and after at least `GATE_DLY` gated cycles, and counts one `ack` per accepted `req`.
